// File: rtl/alu_pkg.sv
// Shared definitions for the ALU datapath and its serial command front end.
package alu_pkg;

  localparam int OPSIZE_DEF = 6;

  localparam int SEL_A_HI = 5;
  localparam int SEL_A_LO = 4;
  localparam int SEL_B_HI = 3;
  localparam int SEL_B_LO = 2;
  localparam int OP_HI    = 1;
  localparam int OP_LO    = 0;

  typedef enum logic [4:0] {
    ST_IDLE   = 5'b00001,
    ST_START  = 5'b00010,
    ST_DATA   = 5'b00100,
    ST_PARITY = 5'b01000,
    ST_STOP   = 5'b10000
  } rx_state_t;

endpackage

// File: rtl/cmd_rx_sync2.sv
// Two-flop synchroniser; reset value is chosen so reset release looks like the idle level.
module sync2 #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/cmd_rx.sv
// Serial command receiver: deserialises start/data/parity/stop frames and holds the
// last correctly framed command word with its parity-mismatch flag.
module cmd_rx
  import alu_pkg::*;
#(
  parameter int OPSIZE       = OPSIZE_DEF,
  parameter int CLKS_PER_BIT = 4,
  parameter int PARITY_ODD   = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ser_in,
  output logic [OPSIZE-1:0] cmd_out,
  output logic              p_error,
  output logic              cmd_valid,
  output logic              frame_error
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int IW = $clog2(OPSIZE + 1);
  localparam logic [CW-1:0] LAST_TICK = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_TICK = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [IW-1:0] LAST_BIT  = IW'(OPSIZE - 1);
  localparam logic          ODD       = (PARITY_ODD != 0);

  rx_state_t         state, next_state;
  logic              rx_s, rx_prev, fall;
  logic [CW-1:0]     bit_cnt;
  logic [IW-1:0]     bit_idx;
  logic [OPSIZE-1:0] shift;
  logic              mismatch;
  logic              tick, cnt_clr, shift_en, par_en, load_good, load_bad;

  sync2 #(.RESET_VAL(1'b1)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (ser_in),
    .q     (rx_s)
  );

  // Edge detector flop also resets high so reset release never fakes a start edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rx_prev <= 1'b1;
    else        rx_prev <= rx_s;
  end

  assign fall = rx_prev & ~rx_s;
  assign tick = (state == ST_START) ? (bit_cnt == HALF_TICK) : (bit_cnt == LAST_TICK);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    unique case (state)
      ST_IDLE:   if (fall) next_state = ST_START;
      ST_START:  if (tick) next_state = rx_s ? ST_IDLE : ST_DATA;
      ST_DATA:   if (tick && bit_idx == LAST_BIT) next_state = ST_PARITY;
      ST_PARITY: if (tick) next_state = ST_STOP;
      ST_STOP:   if (tick) next_state = ST_IDLE;
      default:   next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    cnt_clr   = (state == ST_IDLE) || tick;
    shift_en  = (state == ST_DATA) && tick;
    par_en    = (state == ST_PARITY) && tick;
    load_good = (state == ST_STOP) && tick && rx_s;
    load_bad  = (state == ST_STOP) && tick && !rx_s;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt <= '0;
      bit_idx <= '0;
    end else begin
      bit_cnt <= cnt_clr ? '0 : bit_cnt + 1'b1;
      if (state == ST_IDLE) bit_idx <= '0;
      else if (shift_en)    bit_idx <= bit_idx + 1'b1;
    end
  end

  // Bits arrive LSB first, so shifting in from the top leaves bit 0 at the bottom.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift    <= '0;
      mismatch <= 1'b0;
    end else begin
      if (shift_en) shift    <= {rx_s, shift[OPSIZE-1:1]};
      if (par_en)   mismatch <= (^shift) ^ rx_s ^ ODD;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_out     <= '0;
      p_error     <= 1'b0;
      cmd_valid   <= 1'b0;
      frame_error <= 1'b0;
    end else begin
      cmd_valid   <= load_good;
      frame_error <= load_bad;
      if (load_good) begin
        cmd_out <= shift;
        p_error <= mismatch;
      end
    end
  end

endmodule

// File: tb/tb_cmd_rx.sv
// Bench for cmd_rx: even- and odd-parity receivers share one serial line and are
// checked every cycle against a frame-level model of when and what they should report.
module tb_cmd_rx;

  localparam int OPSIZE  = 6;
  localparam int N       = 4;
  localparam int H       = N / 2;
  localparam int LATENCY = 2 + H + (OPSIZE + 2) * N + 1;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              ser_in = 1'b1;
  logic [OPSIZE-1:0] cmd_e, cmd_o;
  logic              pe_e, pe_o, v_e, v_o, fe_e, fe_o;

  cmd_rx #(.OPSIZE(OPSIZE), .CLKS_PER_BIT(N), .PARITY_ODD(0)) dut_even (
    .clk(clk), .rst_n(rst_n), .ser_in(ser_in),
    .cmd_out(cmd_e), .p_error(pe_e), .cmd_valid(v_e), .frame_error(fe_e)
  );

  cmd_rx #(.OPSIZE(OPSIZE), .CLKS_PER_BIT(N), .PARITY_ODD(1)) dut_odd (
    .clk(clk), .rst_n(rst_n), .ser_in(ser_in),
    .cmd_out(cmd_o), .p_error(pe_o), .cmd_valid(v_o), .frame_error(fe_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    int                cyc;
    bit                good;
    logic [OPSIZE-1:0] data;
    bit                pe_even;
    bit                pe_odd;
  } event_t;

  event_t            pending[$];
  int                cyc;
  int                n_pass;
  int                n_total;
  logic [OPSIZE-1:0] exp_cmd;
  logic              exp_pe_e, exp_pe_o;

  task automatic check_output(string tag, logic [7:0] obs, logic [7:0] expv);
    n_total++;
    assert (obs === expv) n_pass++;
    else $error("[TB] FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, expv, cyc);
  endtask

  task automatic compare_all(logic exp_v, logic exp_fe);
    check_output("even.cmd_out",     8'(cmd_e), 8'(exp_cmd));
    check_output("even.p_error",     8'(pe_e),  8'(exp_pe_e));
    check_output("even.cmd_valid",   8'(v_e),   8'(exp_v));
    check_output("even.frame_error", 8'(fe_e),  8'(exp_fe));
    check_output("odd.cmd_out",      8'(cmd_o), 8'(exp_cmd));
    check_output("odd.p_error",      8'(pe_o),  8'(exp_pe_o));
    check_output("odd.cmd_valid",    8'(v_o),   8'(exp_v));
    check_output("odd.frame_error",  8'(fe_o),  8'(exp_fe));
  endtask

  // Checks the current cycle at the falling edge, then moves just past the next rising edge.
  task automatic step();
    event_t ev;
    logic   exp_v;
    logic   exp_fe;
    exp_v  = 1'b0;
    exp_fe = 1'b0;
    @(negedge clk);
    if (pending.size() > 0 && pending[0].cyc == cyc) begin
      ev = pending.pop_front();
      if (ev.good) begin
        exp_v    = 1'b1;
        exp_cmd  = ev.data;
        exp_pe_e = ev.pe_even;
        exp_pe_o = ev.pe_odd;
      end else begin
        exp_fe = 1'b1;
      end
    end
    compare_all(exp_v, exp_fe);
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic apply_bit(logic b);
    ser_in = b;
    repeat (N) step();
  endtask

  task automatic idle(int n);
    ser_in = 1'b1;
    repeat (n) step();
  endtask

  task automatic apply_frame(logic [OPSIZE-1:0] data, logic par, logic stop);
    int     start;
    event_t ev;
    start = cyc;
    apply_bit(1'b0);
    for (int i = 0; i < OPSIZE; i++) apply_bit(data[i]);
    apply_bit(par);
    apply_bit(stop);
    ev.cyc     = start + LATENCY;
    ev.good    = stop;
    ev.data    = data;
    ev.pe_even = (^data) ^ par;
    ev.pe_odd  = ~((^data) ^ par);
    pending.push_back(ev);
  endtask

  initial begin
    logic [OPSIZE-1:0] d;
    logic              p, s;
    n_pass   = 0;
    n_total  = 0;
    cyc      = 0;
    exp_cmd  = '0;
    exp_pe_e = 1'b0;
    exp_pe_o = 1'b0;

    @(posedge clk);
    #1;
    repeat (3) step();
    rst_n = 1'b1;
    idle(4);

    $display("[TB] good frame and parity error");
    apply_frame(6'b011011, 1'b0, 1'b1);
    idle(3);
    apply_frame(6'b011011, 1'b1, 1'b1);
    idle(3);

    $display("[TB] false start glitch");
    ser_in = 1'b0;
    step();
    idle(10);

    $display("[TB] framing error with line held low");
    apply_frame(6'b110010, 1'b1, 1'b0);
    ser_in = 1'b0;
    repeat (20) step();
    idle(4);
    apply_frame(6'b001110, 1'b0, 1'b1);
    idle(3);

    $display("[TB] reset during data bits");
    apply_bit(1'b0);
    apply_bit(1'b1);
    apply_bit(1'b0);
    rst_n  = 1'b0;
    ser_in = 1'b1;
    #1;
    pending.delete();
    exp_cmd  = '0;
    exp_pe_e = 1'b0;
    exp_pe_o = 1'b0;
    compare_all(1'b0, 1'b0);
    repeat (2) step();
    rst_n = 1'b1;
    idle(4);
    apply_frame(6'b100101, 1'b1, 1'b1);
    idle(3);

    $display("[TB] back-to-back frames");
    apply_frame(6'b000000, 1'b1, 1'b1);
    apply_frame(6'b111111, 1'b1, 1'b1);
    idle(3);

    $display("[TB] random frames");
    for (int k = 0; k < 30; k++) begin
      d = OPSIZE'($urandom);
      p = 1'($urandom);
      s = ($urandom_range(0, 7) != 0);
      apply_frame(d, p, s);
      idle(s ? int'($urandom_range(0, 3)) : int'($urandom_range(1, 3)));
    end

    idle(40);
    check_output("pending_empty", 8'(pending.size()), 8'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
